emu_time_manager: RTL
=====================

Name: emu_time_manager

Overview:
- Consumes the emulator clock `clk` and reset `rst` distributed by the clock-routing stage.
- Generates the global emulation timestep `emu_dt` as the minimum of all model dt requests, clipped to a maximum and to an optional stall time.
- Accumulates emulation time and issues a delayed synchronous model reset.
- Pulses a decimated probe-sample trigger.
- Sits between clock routing and the analog model instances / probe capture.

Parameters:
- N_REQ, 4, number of dt requesters.
- DT_WIDTH, 16, width of each dt request and of `emu_dt` (unsigned, time LSBs).
- TIME_WIDTH, 40, width of `emu_time` and `stall_time` (unsigned).
- DT_MAX, 16'hFFFF, upper clip applied to `emu_dt`.
- RST_CYCLES, 4, cycles `emu_rst` stays high after `rst` deasserts (≥1).
- DEC_WIDTH, 16, width of decimation threshold/counter.

Ports:
- clk  input  1  emulator clock.
- rst  input  1  reset, asynchronous, active-low.
- dt_req  input  N_REQ*DT_WIDTH  packed dt requests; requester i occupies bits [i*DT_WIDTH +: DT_WIDTH].
- stall_en  input  1  enables the stall-time limit.
- stall_time  input  TIME_WIDTH  emulation time at which to stop advancing.
- dec_thr  input  DEC_WIDTH  trigger every dec_thr+1 nonzero steps.
- emu_rst  output  1  synchronous active-high reset to models.
- emu_dt  output  DT_WIDTH  timestep committed at next edge (combinational from registered state and inputs).
- emu_time  output  TIME_WIDTH  accumulated emulation time (registered).
- stalled  output  1  high while in STALL.
- dec_trig  output  1  one-cycle registered probe trigger.

Behaviour:
- Async reset (rst=0) sets:
  - state=HOLD, emu_rst=1, emu_time=0, hold counter=0, dec_cnt=0, dec_trig=0, stalled=0.
  - emu_dt=0 combinationally whenever state≠RUN.
- State machine:
  - HOLD:
    - emu_rst=1; hold counter increments each edge.
    - After RST_CYCLES edges following rst release: go to RUN, emu_rst<=0.
  - RUN:
    - dt_min = unsigned minimum of all N_REQ requests.
    - dt_c = min(dt_min, DT_MAX).
    - If stall_en and emu_time ≥ stall_time: emu_dt=0, next state STALL.
    - Else if stall_en and emu_time+dt_c > stall_time: emu_dt = stall_time − emu_time.
    - Else emu_dt = dt_c.
  - STALL:
    - stalled=1 (registered, asserted from the first STALL cycle); emu_dt=0.
    - Return to RUN on the edge where stall_en=0 or stall_time > emu_time.
- Time update:
  - emu_time <= emu_time + emu_dt every edge, computed at TIME_WIDTH+1 bits.
  - On overflow, emu_time saturates at all-ones.
  - Once saturated, emu_dt=0 (treated like STALL but stalled stays 0).
- Zero request: any dt_req=0 gives emu_dt=0; time holds. This is not a stall.
- Decimation:
  - On each edge in RUN with emu_dt≠0: if dec_cnt ≥ dec_thr, then dec_cnt<=0 and dec_trig<=1; else dec_cnt++ and dec_trig<=0.
  - Otherwise dec_trig<=0 and dec_cnt holds.
  - If dec_thr is lowered below dec_cnt, the trigger fires on the next nonzero step.
  - dec_thr=0 gives a trigger after every nonzero step.
- Reset mid-operation:
  - rst low at any time returns immediately (asynchronously) to the reset values.
  - The HOLD sequence restarts on release.
- Simultaneous events: stall reached on the same cycle as a decimation match. The step that lands exactly on stall_time counts and can trigger. The following zero step neither counts nor triggers.

Test Plan:
- Reset release, RST_CYCLES=4, all requests 10 -> emu_rst high 4 cycles after rst↑, emu_dt=0 and emu_time=0 during HOLD. Then emu_dt=10 and emu_time 10,20,30.
- Requests {7,3,9,5}, DT_MAX=4 -> emu_dt=3. Change to {7,8,9,5} -> emu_dt=4 (clipped).
- stall_en=1, stall_time=25, requests all 10 -> emu_time 10,20,25 (last emu_dt=5), then stalled=1, emu_dt=0. Raise stall_time to 40 -> resumes 35,40, stalls again.
- dec_thr=2, requests all 1 -> dec_trig pulses after steps 3,6,9. Force one request to 0 for 2 cycles -> no count, trigger spacing stretches by 2 cycles.
- Assert rst low mid-run at emu_time=500 -> all outputs return to reset values without a clock edge, and the HOLD sequence repeats.
- TIME_WIDTH=8, requests 100 -> emu_time 100,200,255 (saturated), then emu_dt=0, stalled=0.

Source files
------------

// File: rtl/emu_time_manager.sv
// emu_time_manager
// Produces the global emulation timestep from the model dt requests.
// Accumulates emulation time with saturation and holds the models in
// reset for a few cycles after the emulator reset releases. It also
// pulses a decimated trigger for probe capture.
module emu_time_manager #(
    parameter int                  N_REQ      = 4,
    parameter int                  DT_WIDTH   = 16,
    parameter int                  TIME_WIDTH = 40,
    parameter logic [DT_WIDTH-1:0] DT_MAX     = {DT_WIDTH{1'b1}},
    parameter int                  RST_CYCLES = 4,
    parameter int                  DEC_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
    input  logic                      stall_en,
    input  logic [TIME_WIDTH-1:0]     stall_time,
    input  logic [DEC_WIDTH-1:0]      dec_thr,
    output logic                      emu_rst,
    output logic [DT_WIDTH-1:0]       emu_dt,
    output logic [TIME_WIDTH-1:0]     emu_time,
    output logic                      stalled,
    output logic                      dec_trig
);

    localparam logic [1:0] ST_HOLD  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    // The hold counter only has to reach RST_CYCLES-1.
    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    // Time arithmetic is done one bit wider than the wider operand.
    // This keeps carries and comparisons exact.
    localparam int SUM_W = ((TIME_WIDTH > DT_WIDTH) ? TIME_WIDTH : DT_WIDTH) + 1;

    localparam logic [TIME_WIDTH-1:0] TIME_MAX = {TIME_WIDTH{1'b1}};

    logic [1:0]            state_q,    state_d;
    logic                  emu_rst_q,  emu_rst_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [TIME_WIDTH-1:0] emu_time_q, emu_time_d;
    logic [DEC_WIDTH-1:0]  dec_cnt_q,  dec_cnt_d;
    logic                  dec_trig_q, dec_trig_d;
    logic                  stalled_q,  stalled_d;

    logic [DT_WIDTH-1:0]   dt_min;
    logic [DT_WIDTH-1:0]   dt_c;
    logic [DT_WIDTH-1:0]   emu_dt_c;
    logic [SUM_W-1:0]      time_ext;
    logic [SUM_W-1:0]      stall_ext;
    logic [SUM_W-1:0]      reach_sum;
    logic [SUM_W-1:0]      step_sum;
    logic                  saturated;

    // Smallest request across all requesters, then clipped to DT_MAX.
    always_comb begin
        dt_min = {DT_WIDTH{1'b1}};
        for (int i = 0; i < N_REQ; i++) begin
            if (dt_req[i*DT_WIDTH +: DT_WIDTH] < dt_min) begin
                dt_min = dt_req[i*DT_WIDTH +: DT_WIDTH];
            end
        end
        dt_c = (dt_min > DT_MAX) ? DT_MAX : dt_min;
    end

    // Sequencing: reset hold, running, and stall at stall_time. Also picks the step for this cycle.
    always_comb begin
        state_d    = state_q;
        emu_rst_d  = emu_rst_q;
        hold_cnt_d = hold_cnt_q;
        emu_dt_c   = '0;
        time_ext   = SUM_W'(emu_time_q);
        stall_ext  = SUM_W'(stall_time);
        reach_sum  = time_ext + SUM_W'(dt_c);
        saturated  = (emu_time_q == TIME_MAX);
        case (state_q)
            ST_HOLD: begin
                emu_rst_d = 1'b1;
                if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
                    state_d    = ST_RUN;
                    emu_rst_d  = 1'b0;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (stall_en && (time_ext >= stall_ext)) begin
                    state_d = ST_STALL;
                end else if (saturated) begin
                    emu_dt_c = '0;
                end else if (stall_en && (reach_sum > stall_ext)) begin
                    emu_dt_c = DT_WIDTH'(stall_ext - time_ext);
                end else begin
                    emu_dt_c = dt_c;
                end
            end
            ST_STALL: begin
                if (!stall_en || (stall_ext > time_ext)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d   = ST_HOLD;
                emu_rst_d = 1'b1;
            end
        endcase
    end

    // Time accumulation with saturation at all-ones. Stalled follows the next state.
    always_comb begin
        step_sum   = SUM_W'(emu_time_q) + SUM_W'(emu_dt_c);
        emu_time_d = (step_sum > SUM_W'(TIME_MAX)) ? TIME_MAX : step_sum[TIME_WIDTH-1:0];
        stalled_d  = (state_d == ST_STALL);
    end

    // Decimation counter. Only real, nonzero steps taken in RUN count toward the trigger.
    always_comb begin
        dec_cnt_d  = dec_cnt_q;
        dec_trig_d = 1'b0;
        if ((state_q == ST_RUN) && (emu_dt_c != '0)) begin
            if (dec_cnt_q >= dec_thr) begin
                dec_cnt_d  = '0;
                dec_trig_d = 1'b1;
            end else begin
                dec_cnt_d = dec_cnt_q + DEC_WIDTH'(1);
            end
        end
    end

    // State registers. Asynchronous active-low reset restarts the hold sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_HOLD;
            emu_rst_q  <= 1'b1;
            hold_cnt_q <= '0;
            emu_time_q <= '0;
            dec_cnt_q  <= '0;
            dec_trig_q <= 1'b0;
            stalled_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            emu_rst_q  <= emu_rst_d;
            hold_cnt_q <= hold_cnt_d;
            emu_time_q <= emu_time_d;
            dec_cnt_q  <= dec_cnt_d;
            dec_trig_q <= dec_trig_d;
            stalled_q  <= stalled_d;
        end
    end

    assign emu_rst  = emu_rst_q;
    assign emu_dt   = emu_dt_c;
    assign emu_time = emu_time_q;
    assign stalled  = stalled_q;
    assign dec_trig = dec_trig_q;

endmodule
